mem_ecc_scrubber: RTL and testbench

MEM_ECC_SCRUBBER -- requirements
Module: mem_ecc_scrubber

---
 rtl/mem_ecc_scrubber_pkg.sv | 76 +++++++
 rtl/mem_ecc_scrubber_if.sv | 25 ++
 rtl/mem_ecc_scrubber_secded_dec32.sv | 37 +++
 rtl/mem_ecc_scrubber.sv | 166 ++++++++++++++++
 tb/tb_mem_ecc_scrubber.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ecc_scrubber_pkg.sv
// Shared SECDED(39,32) definitions for the scrubber: code widths, FSM states,
// and the Hamming placement / syndrome / encode helpers.
package ecc_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CHECK_W = 7;
    localparam int unsigned CODE_W  = 39;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        READ,
        CHECK,
        WRITE,
        NEXT,
        DONE
    } state_t;

    // Hamming positions 1..38; the overall parity bit c6 lives outside this vector.
    typedef logic [CODE_W-1:1] hamming_t;

    function automatic logic is_pow2(input int unsigned p);
        return ((p & (p - 32'd1)) == 32'd0);
    endfunction

    function automatic hamming_t ecc_place(input logic [DATA_W-1:0] d);
        hamming_t    cw;
        int unsigned k;
        cw = '0;
        k  = 0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (!is_pow2(p)) begin
                cw[6'(p)] = d[5'(k)];
                k++;
            end
        end
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] ecc_extract(input hamming_t cw);
        logic [DATA_W-1:0] d;
        int unsigned       k;
        d = '0;
        k = 0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (!is_pow2(p)) begin
                d[5'(k)] = cw[6'(p)];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [5:0] ecc_syndrome(input hamming_t cw);
        logic [5:0] s;
        s = '0;
        for (int unsigned b = 0; b < 6; b++) begin
            for (int unsigned p = 1; p < CODE_W; p++) begin
                if (((p >> b) & 32'd1) != 32'd0) begin
                    s[3'(b)] = s[3'(b)] ^ cw[6'(p)];
                end
            end
        end
        return s;
    endfunction

    // With the check positions empty, the syndrome of the data alone is c0..c5.
    function automatic logic [CHECK_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
        hamming_t   cw;
        logic [5:0] c;
        cw = ecc_place(d);
        c  = ecc_syndrome(cw);
        return {(^cw) ^ (^c), c};
    endfunction

endpackage

// File: rtl/mem_ecc_scrubber_if.sv
// Native memory-bus link between the scrubber (initiator) and the memory (responder).
interface mem_ecc_scrubber_if;
    import ecc_pkg::*;

    logic               mem_valid;
    logic               mem_instr;
    logic               mem_ready;
    logic [31:0]        mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [CHECK_W-1:0] mem_wcheck;
    logic [3:0]         mem_wstrb;
    logic [DATA_W-1:0]  mem_rdata;
    logic [CHECK_W-1:0] mem_rcheck;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wcheck, mem_wstrb,
        input  mem_ready, mem_rdata, mem_rcheck
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wcheck, mem_wstrb,
        output mem_ready, mem_rdata, mem_rcheck
    );

endinterface

// File: rtl/mem_ecc_scrubber_secded_dec32.sv
// Combinational SECDED(39,32) decoder: corrects single-bit errors, flags double-bit ones.
module secded_dec32
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [CHECK_W-1:0] i_check,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_correctable,
    output logic               o_uncorrectable
);

    hamming_t   w_cw;
    hamming_t   w_fix;
    logic [5:0] w_syn;
    logic       w_par;

    always_comb begin
        w_cw     = ecc_place(i_data);
        w_cw[1]  = i_check[0];
        w_cw[2]  = i_check[1];
        w_cw[4]  = i_check[2];
        w_cw[8]  = i_check[3];
        w_cw[16] = i_check[4];
        w_cw[32] = i_check[5];
        w_syn    = ecc_syndrome(w_cw);
        w_par    = (^w_cw) ^ i_check[6];
        w_fix    = w_cw;
        // s=0 with odd parity means only c6 flipped; data needs no fix.
        if (w_par && (w_syn != 6'd0) && (w_syn <= 6'd38)) begin
            w_fix[w_syn] = ~w_cw[w_syn];
        end
        o_data          = ecc_extract(w_fix);
        o_correctable   = w_par && (w_syn <= 6'd38);
        o_uncorrectable = (!w_par && (w_syn != 6'd0)) || (w_par && (w_syn > 6'd38));
    end

endmodule

// File: rtl/mem_ecc_scrubber.sv
// Background memory scrubber: walks a word range, corrects single-bit ECC errors
// in place and counts/reports uncorrectable words.
module mem_ecc_scrubber
    import ecc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    mem_ecc_scrubber_if.master mem,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        err_addr,
    output logic [15:0]        corr_count,
    output logic [15:0]        uncorr_count
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((NUM_WORDS - 1) * 4);
    localparam int unsigned GW        = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [GW-1:0]      r_gap;
    logic               r_abort;
    logic               r_valid;
    logic [3:0]         r_wstrb;
    logic [DATA_W-1:0]  r_wdata;
    logic [CHECK_W-1:0] r_wcheck;
    logic [DATA_W-1:0]  r_rdata;
    logic [CHECK_W-1:0] r_rcheck;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_err_addr;
    logic [15:0]        r_corr;
    logic [15:0]        r_uncorr;

    logic [DATA_W-1:0]  w_fix_data;
    logic               w_correctable;
    logic               w_uncorrectable;

    secded_dec32 u_dec (
        .i_data         (r_rdata),
        .i_check        (r_rcheck),
        .o_data         (w_fix_data),
        .o_correctable  (w_correctable),
        .o_uncorrectable(w_uncorrectable)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_gap      <= '0;
            r_abort    <= 1'b0;
            r_valid    <= 1'b0;
            r_wstrb    <= '0;
            r_wdata    <= '0;
            r_wcheck   <= '0;
            r_rdata    <= '0;
            r_rcheck   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_corr     <= '0;
            r_uncorr   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Abort only latches mid-pass; the NEXT->DONE clear below takes precedence.
            if (abort && (r_state != IDLE) && (r_state != DONE)) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= BASE_ADDR;
                        r_gap   <= GAP_INIT;
                        r_abort <= abort;
                        r_busy  <= 1'b1;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        r_valid <= 1'b1;
                        r_wstrb <= 4'b0000;
                        r_state <= READ;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                READ: begin
                    if (mem.mem_ready) begin
                        r_valid  <= 1'b0;
                        r_rdata  <= mem.mem_rdata;
                        r_rcheck <= mem.mem_rcheck;
                        r_state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_uncorrectable) begin
                        if (r_uncorr != 16'hFFFF) r_uncorr <= r_uncorr + 16'd1;
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                        r_state    <= NEXT;
                    end else if (w_correctable) begin
                        if (r_corr != 16'hFFFF) r_corr <= r_corr + 16'd1;
                        r_wdata  <= w_fix_data;
                        r_wcheck <= ecc_encode(w_fix_data);
                        r_valid  <= 1'b1;
                        r_wstrb  <= 4'b1111;
                        r_state  <= WRITE;
                    end else begin
                        r_state <= NEXT;
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        r_valid <= 1'b0;
                        r_wstrb <= 4'b0000;
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if ((r_addr == LAST_ADDR) || r_abort) begin
                        r_abort <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_addr  <= r_addr + 32'd4;
                        r_gap   <= GAP_INIT;
                        r_state <= GAP;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_valid  = r_valid;
    assign mem.mem_instr  = 1'b0;
    assign mem.mem_addr   = r_addr;
    assign mem.mem_wdata  = r_wdata;
    assign mem.mem_wcheck = r_wcheck;
    assign mem.mem_wstrb  = r_wstrb;

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign err_addr     = r_err_addr;
    assign corr_count   = r_corr;
    assign uncorr_count = r_uncorr;

endmodule

// File: tb/tb_mem_ecc_scrubber.sv
// Scoreboard bench for mem_ecc_scrubber: a 4-word memory model answers the bus,
// a monitor matches every bus transfer, err and done pulse against queued expectations.
module tb_mem_ecc_scrubber;

    localparam int unsigned KIND_BUS  = 0;
    localparam int unsigned KIND_ERR  = 1;
    localparam int unsigned KIND_DONE = 2;

    typedef struct {
        int unsigned kind;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [6:0]  wcheck;
    } ev_t;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;

    mem_ecc_scrubber_if bus ();

    mem_ecc_scrubber #(
        .BASE_ADDR (32'h0000_0000),
        .NUM_WORDS (4),
        .GAP_CYCLES(2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .mem         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_addr    (err_addr),
        .corr_count  (corr_count),
        .uncorr_count(uncorr_count)
    );

    initial forever #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 0;
    ev_t         exp_q[$];
    logic [31:0] m_data[4];
    logic [6:0]  m_chk[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void exp_rd(input logic [31:0] a);
        exp_q.push_back('{KIND_BUS, a, 4'h0, 32'h0, 7'h0});
    endfunction

    function automatic void exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [6:0] c);
        exp_q.push_back('{KIND_BUS, a, 4'hF, d, c});
    endfunction

    function automatic void exp_err(input logic [31:0] a);
        exp_q.push_back('{KIND_ERR, a, 4'h0, 32'h0, 7'h0});
    endfunction

    function automatic void exp_done();
        exp_q.push_back('{KIND_DONE, 32'h0, 4'h0, 32'h0, 7'h0});
    endfunction

    // Memory responder: ready after 'lat' waiting cycles, inputs change 1ns after the edge.
    initial begin
        int         wait_cnt;
        logic [1:0] idx;
        wait_cnt       = 0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rcheck = '0;
        forever begin
            @(posedge clk);
            #1;
            idx = bus.mem_addr[3:2];
            if (!resetn) begin
                bus.mem_ready = 1'b0;
                wait_cnt      = 0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                wait_cnt      = 0;
            end else if (bus.mem_valid) begin
                if (wait_cnt >= lat) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_wstrb == 4'hF) begin
                        m_data[idx] = bus.mem_wdata;
                        m_chk[idx]  = bus.mem_wcheck;
                    end else begin
                        bus.mem_rdata  = m_data[idx];
                        bus.mem_rcheck = m_chk[idx];
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        logic        in_xfer;
        logic        stable;
        logic        drop_pending;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic [6:0]  h_wcheck;
        logic [3:0]  h_wstrb;
        ev_t         e;
        in_xfer      = 1'b0;
        stable       = 1'b1;
        drop_pending = 1'b0;
        h_addr       = '0;
        h_wdata      = '0;
        h_wcheck     = '0;
        h_wstrb      = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_xfer      = 1'b0;
                drop_pending = 1'b0;
            end else begin
                if (drop_pending) begin
                    check("valid_low_after_ready", 64'(bus.mem_valid), 64'(0));
                    drop_pending = 1'b0;
                end
                if (bus.mem_valid) begin
                    if (in_xfer) begin
                        if (bus.mem_addr !== h_addr || bus.mem_wdata !== h_wdata ||
                            bus.mem_wcheck !== h_wcheck || bus.mem_wstrb !== h_wstrb)
                            stable = 1'b0;
                    end else begin
                        in_xfer  = 1'b1;
                        stable   = 1'b1;
                        h_addr   = bus.mem_addr;
                        h_wdata  = bus.mem_wdata;
                        h_wcheck = bus.mem_wcheck;
                        h_wstrb  = bus.mem_wstrb;
                    end
                    if (bus.mem_ready) begin
                        check("bus_hold_stable", 64'(stable), 64'(1));
                        in_xfer      = 1'b0;
                        drop_pending = 1'b1;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL bus_unexpected: got access addr=0x%0h wstrb=0x%0h, expected none",
                                     bus.mem_addr, bus.mem_wstrb);
                        end else begin
                            e = exp_q.pop_front();
                            check("bus_event_kind", 64'(KIND_BUS), 64'(e.kind));
                            check("bus_addr", 64'(bus.mem_addr), 64'(e.addr));
                            check("bus_wstrb", 64'(bus.mem_wstrb), 64'(e.wstrb));
                            if (e.wstrb == 4'hF) begin
                                check("bus_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
                                check("bus_wcheck", 64'(bus.mem_wcheck), 64'(e.wcheck));
                            end
                        end
                    end
                end else if (in_xfer) begin
                    check("valid_held_until_ready", 64'(bus.mem_valid), 64'(1));
                    in_xfer = 1'b0;
                end
                if (err) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL err_unexpected: got err pulse addr=0x%0h, expected none", err_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("err_event_kind", 64'(KIND_ERR), 64'(e.kind));
                        check("err_addr", 64'(err_addr), 64'(e.addr));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL done_unexpected: got done pulse, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check("done_event_kind", 64'(KIND_DONE), 64'(e.kind));
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'(0));
        check({tag, "_mem_instr"}, 64'(bus.mem_instr), 64'(0));
        check({tag, "_mem_wstrb"}, 64'(bus.mem_wstrb), 64'(0));
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
        check({tag, "_mem_wcheck"}, 64'(bus.mem_wcheck), 64'(0));
        check({tag, "_busy_done_err"}, 64'({busy, done, err}), 64'(0));
        check({tag, "_err_addr"}, 64'(err_addr), 64'(0));
        check({tag, "_counters"}, 64'({corr_count, uncorr_count}), 64'(0));
    endtask

    task automatic pulse_start(input logic with_abort);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n;
        n = 0;
        check({name, "_busy"}, 64'(busy), 64'(1));
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check({name, "_events_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_bus(input logic [31:0] a, input logic [3:0] strb, input string name);
        int unsigned n;
        n = 0;
        while (!(bus.mem_valid && bus.mem_addr == a && bus.mem_wstrb == strb) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached"}, 64'(bus.mem_valid && bus.mem_addr == a && bus.mem_wstrb == strb), 64'(1));
    endtask

    initial begin
        int seen_valid;
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
        seen_valid = 0;
    end

    initial begin
        int seen_valid;
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0;
            m_chk[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Clean memory: four reads, no writes.
        lat = 0;
        exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_rd(32'hC); exp_done();
        pulse_start(1'b0);
        wait_idle("clean");
        check("clean_counters", 64'({corr_count, uncorr_count}), 64'(0));

        // d5 flipped at 0x8 -> corrected write-back of zero.
        m_data[2] = 32'h0000_0020;
        exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_wr(32'h8, 32'h0, 7'h00); exp_rd(32'hC); exp_done();
        pulse_start(1'b0);
        wait_idle("single");
        check("single_corr_count", 64'(corr_count), 64'(1));
        check("single_uncorr_count", 64'(uncorr_count), 64'(0));
        check("single_mem_fixed", 64'({m_data[2], m_chk[2]}), 64'(0));

        // d5 and d17 flipped at 0x4 -> err pulse, no write; counters survive start.
        m_data[1] = 32'h0002_0020;
        exp_rd(32'h0); exp_rd(32'h4); exp_err(32'h4); exp_rd(32'h8); exp_rd(32'hC); exp_done();
        pulse_start(1'b0);
        wait_idle("double");
        check("double_uncorr_count", 64'(uncorr_count), 64'(1));
        check("double_corr_kept", 64'(corr_count), 64'(1));
        check("double_err_addr", 64'(err_addr), 64'(32'h4));
        check("double_mem_untouched", 64'(m_data[1]), 64'(32'h0002_0020));

        // Slow responder; 0x4 = true 0x1/0x43 with d1 flipped, 0x8 clean nonzero, 0xC c6-only.
        lat = 5;
        m_data[1] = 32'h0000_0003; m_chk[1] = 7'h43;
        m_data[2] = 32'h0000_0001; m_chk[2] = 7'h43;
        m_data[3] = 32'h0000_0000; m_chk[3] = 7'h40;
        exp_rd(32'h0); exp_rd(32'h4); exp_wr(32'h4, 32'h1, 7'h43); exp_rd(32'h8);
        exp_rd(32'hC); exp_wr(32'hC, 32'h0, 7'h00); exp_done();
        pulse_start(1'b0);
        wait_idle("slow");
        check("slow_corr_count", 64'(corr_count), 64'(3));
        check("slow_mem_word1", 64'({m_data[1], m_chk[1]}), 64'({32'h1, 7'h43}));
        check("slow_mem_word3", 64'({m_data[3], m_chk[3]}), 64'(0));

        // Abort during the read of word 1: pass ends after it.
        exp_rd(32'h0); exp_rd(32'h4); exp_done();
        pulse_start(1'b0);
        wait_bus(32'h4, 4'h0, "abort_read1");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort");

        // start and abort together: one word only.
        lat = 0;
        exp_rd(32'h0); exp_done();
        pulse_start(1'b1);
        wait_idle("start_abort");

        // Abort in IDLE is discarded: full pass follows.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_rd(32'hC); exp_done();
        pulse_start(1'b0);
        wait_idle("idle_abort");

        // Reset while a write-back is waiting for ready.
        lat = 50;
        m_data[1] = 32'h0000_0020; m_chk[1] = 7'h00;
        exp_rd(32'h0); exp_rd(32'h4); exp_wr(32'h4, 32'h0, 7'h00);
        pulse_start(1'b0);
        wait_bus(32'h4, 4'hF, "reset_write");
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("reset_in_write");
        check("reset_pending_write", 64'(exp_q.size()), 64'(1));
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        lat = 0;
        seen_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.mem_valid) seen_valid++;
        end
        check("post_reset_bus_idle", 64'(seen_valid), 64'(0));
        check("post_reset_busy", 64'(busy), 64'(0));
        check("post_reset_no_writeback", 64'(m_data[1]), 64'(32'h0000_0020));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
